// File: rtl/tail_light_decoder.sv
// Passive monitor for the two tail-light lamp buses: recovers turn/brake
// commands from the step patterns and flags code, order, timing and symmetry errors.
module tail_light_decoder #(
  parameter int STEP_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] right_tail_light,
  input  logic [2:0] left_tail_light,
  input  logic       clr_err,
  output logic       turn_right_det,
  output logic       turn_left_det,
  output logic       brake_det,
  output logic [3:0] err_flags,
  output logic       err_pulse
);

  localparam int RUN_W = $clog2(STEP_CYCLES + 2);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STEP_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_STEP = RUN_W'(STEP_CYCLES);

  localparam logic [2:0] C_OFF = 3'b000;
  localparam logic [2:0] C_ONE = 3'b001;
  localparam logic [2:0] C_TWO = 3'b011;
  localparam logic [2:0] C_ALL = 3'b111;

  // Side index 0 is the right bus, 1 is the left bus.
  logic [1:0][2:0]       sample, prev_q;
  logic [1:0][RUN_W-1:0] run_q, run_d;
  logic [1:0]            changed, illegal, order_err, time_err;
  logic [1:0]            on_d, idle_d, turn_set, turn_clr;
  logic                  asym_err;
  logic [3:0]            new_err;

  assign sample = {left_tail_light, right_tail_light};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    changed   = '0;
    illegal   = '0;
    order_err = '0;
    time_err  = '0;
    on_d      = '0;
    idle_d    = '0;
    turn_set  = '0;
    turn_clr  = '0;
    run_d     = '0;
    for (int i = 0; i < 2; i++) begin
      changed[i] = (sample[i] != prev_q[i]);
      illegal[i] = !(sample[i] inside {C_OFF, C_ONE, C_TWO, C_ALL});

      if (changed[i] || illegal[i])
        run_d[i] = RUN_W'(1);
      else if (run_q[i] == RUN_MAX)
        run_d[i] = RUN_MAX;
      else
        run_d[i] = run_q[i] + 1'b1;

      on_d[i]   = (sample[i] == C_ALL) && (run_d[i] == RUN_MAX);
      idle_d[i] = (sample[i] == C_OFF) && (run_d[i] == RUN_MAX);

      // 111 and 000 may be entered from anywhere (brake override, abort).
      order_err[i] = changed[i] &&
                     (((sample[i] == C_ONE) && (prev_q[i] != C_OFF)) ||
                      ((sample[i] == C_TWO) && (prev_q[i] != C_ONE)));

      // Overlong hold of an intermediate step, or a legal advance taken too early.
      time_err[i] = (!changed[i] && (run_q[i] == RUN_STEP) &&
                     ((sample[i] == C_ONE) || (sample[i] == C_TWO))) ||
                    (changed[i] && (run_q[i] < RUN_STEP) &&
                     (((prev_q[i] == C_ONE) && (sample[i] == C_TWO)) ||
                      ((prev_q[i] == C_TWO) && (sample[i] == C_ALL))));

      turn_set[i] = (prev_q[i] == C_OFF) && (sample[i] == C_ONE);
      turn_clr[i] = on_d[i] | idle_d[i];
    end
    asym_err = (on_d[1] & idle_d[0]) | (on_d[0] & idle_d[1]);
    new_err  = {asym_err, |time_err, |order_err, |illegal};
  end

  always_ff @(posedge clk) begin
    // NOTE: state is only a few flops, so everything is reset; run starts
    // saturated so both buses look idle and the first sample raises nothing spurious.
    if (!rst_n) begin
      prev_q         <= '0;
      run_q          <= {2{RUN_MAX}};
      turn_right_det <= 1'b0;
      turn_left_det  <= 1'b0;
      brake_det      <= 1'b0;
      err_flags      <= '0;
      err_pulse      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      prev_q         <= sample;
      run_q          <= run_d;
      turn_right_det <= turn_set[0] | (turn_right_det & ~turn_clr[0]);
      turn_left_det  <= turn_set[1] | (turn_left_det & ~turn_clr[1]);
      brake_det      <= |on_d;
      // A fresh error on the clearing edge still lands.
      err_flags      <= (clr_err ? 4'b0000 : err_flags) | new_err;
      err_pulse      <= |new_err;
    end
  end

endmodule
